alu4_resp: RTL and testbench
============================

ALU4_RESP -- requirements
Module: alu4_resp

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the result FIFO depth; it is a power of two and at least 2.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 cmd_valid  input  1  SHALL indicate that a command is presented.
REQ-005 cmd_ready  output  1  SHALL indicate that the block accepts a command this cycle.
REQ-006 cmd_a, cmd_b  input  4 each  SHALL be the operands.
REQ-007 cmd_sel  input  3  SHALL be the opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 compare.
REQ-008 res_valid  output  1  SHALL indicate that the FIFO head result is valid.
REQ-009 res_ready  input  1  SHALL indicate that the consumer takes the head result this cycle.
REQ-010 res_out  output  4  SHALL be the head result value.
REQ-011 res_carry  output  1  SHALL be the head result carry/borrow flag.
REQ-012 res_zero  output  1  SHALL be high when res_out is 0000.
REQ-013 op_count  output  8  SHALL count accepted commands.

Function
REQ-014 Accept SHALL occur on cycle edges where cmd_valid && cmd_ready; pop SHALL occur where res_valid && res_ready.
REQ-015 cmd_ready SHALL be high exactly when FIFO occupancy is below DEPTH; it SHALL NOT depend combinationally on res_ready.
REQ-016 Add SHALL give out = (A+B)[3:0] and carry = bit 4 of the 5-bit sum.
REQ-017 Sub SHALL give out = (A-B) mod 16 and carry = 1 iff A < B (borrow).
REQ-018 And, or and xor SHALL be bitwise, with carry = 0.
REQ-019 Shl SHALL give out = {A[2:0],0} and carry = A[3]; shr SHALL give out = {0,A[3:1]} and carry = A[0]; B is ignored for both.
REQ-020 Compare SHALL give out = {0, A<B, A>B, A==B} (bit0 eq, bit1 gt, bit2 lt) and carry = 0.
REQ-021 Latency SHALL be one cycle: a result accepted at edge N is written to the FIFO at edge N and res_valid is high from the following cycle if the FIFO was empty.
REQ-022 Results SHALL leave in acceptance order.
REQ-023 res_out, res_carry and res_zero SHALL hold stable while res_valid is high and res_ready is low.
REQ-024 Push and pop at the same edge SHALL leave occupancy unchanged, including at occupancy DEPTH-1 and at occupancy 1.
REQ-025 At full, the edge that pops SHALL NOT also accept (cmd_ready was low); cmd_ready SHALL rise the next cycle.
REQ-026 At empty, res_valid SHALL be low and res_ready SHALL be ignored.
REQ-027 op_count SHALL increment by 1 per accept and wrap from 255 to 0.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with log2(DEPTH)+1 bits.

Reset
REQ-029 Asserting rst SHALL immediately clear occupancy, both pointers and op_count, set res_valid low and set cmd_ready high.
REQ-030 res_out, res_carry and res_zero SHALL read 0, 0, 1 during reset.
REQ-031 Commands and results in flight at reset SHALL be discarded; the first accept after deassertion SHALL behave as if from power-up.

Structure
REQ-032 Opcode constants (OP_ADD..OP_CMP) and the 4-bit data width SHALL reside in shared package alu4_pkg.
REQ-033 Opcode evaluation SHALL be a combinational sub-module alu4_core (a, b, sel -> out, carry); the FIFO, counter and handshake logic SHALL live in alu4_resp.

Verification
REQ-034 The bench SHALL hold A=0101, B=0011 and sweep sel 000..111 with res_ready=1, expecting out/carry 1000/0, 0010/0, 0001/0, 0111/0, 0110/0, 1010/0, 0010/1, 0010/0.
REQ-035 The bench SHALL drive A=1111, B=0001 with add then sub, expecting 0000/carry1/zero1 then 1110/0; then A=0011, B=0101 with sub, expecting 1110/carry1.
REQ-036 The bench SHALL hold res_ready=0 and issue 3 commands, expecting cmd_ready low after 2 accepts; it then raises res_ready for one cycle and expects cmd_ready high the next cycle and the third command to be accepted.
REQ-037 The bench SHALL run continuous cmd_valid=1 and res_ready=1 for 20 cycles, expecting throughput of 1 per cycle, in-order results and op_count=20.
REQ-038 The bench SHALL assert rst asynchronously mid-cycle with 2 results queued, expecting res_valid=0, cmd_ready=1 and op_count=0 before the next clk edge.
REQ-039 The bench SHALL issue 257 accepts, expecting op_count=1.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU with result FIFO: data width,
// opcode encoding and the stored result record.
package alu4_pkg;

   localparam int DATA_W = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_CMP = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic [DATA_W-1:0] out;
      logic              carry;
   } alu_res_t;

endpackage

// File: rtl/alu4_core.sv
// Combinational opcode evaluation: operands and opcode in, result and
// carry/borrow flag out.
module alu4_core
   import alu4_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        sel,
   output logic [DATA_W-1:0] out,
   output logic              carry
);

   logic [DATA_W:0] wide;

   always_comb begin
      wide  = '0;
      out   = '0;
      carry = 1'b0;
      case (alu_op_e'(sel))
         OP_ADD: begin
            wide  = {1'b0, a} + {1'b0, b};
            out   = wide[DATA_W-1:0];
            carry = wide[DATA_W];
         end
         // The fifth bit of the widened difference is the borrow (a < b).
         OP_SUB: begin
            wide  = {1'b0, a} - {1'b0, b};
            out   = wide[DATA_W-1:0];
            carry = wide[DATA_W];
         end
         OP_AND: out = a & b;
         OP_OR:  out = a | b;
         OP_XOR: out = a ^ b;
         OP_SHL: begin
            out   = {a[DATA_W-2:0], 1'b0};
            carry = a[DATA_W-1];
         end
         OP_SHR: begin
            out   = {1'b0, a[DATA_W-1:1]};
            carry = a[0];
         end
         OP_CMP: out = {1'b0, (a < b), (a > b), (a == b)};
         default: begin
            out   = '0;
            carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu4_resp.sv
// ALU front end with a DEPTH-entry in-order result FIFO, valid/ready
// handshakes on both sides and a wrapping accepted-command counter.
module alu4_resp
   import alu4_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [2:0]        cmd_sel,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_out,
   output logic              res_carry,
   output logic              res_zero,
   output logic [7:0]        op_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       op_count_q, op_count_d;

   alu_res_t          mem_q [DEPTH];
   alu_res_t          head;
   logic [DATA_W-1:0] alu_out;
   logic              alu_carry;
   logic              push;
   logic              pop;

   alu4_core u_core (
      .a     (cmd_a),
      .b     (cmd_b),
      .sel   (cmd_sel),
      .out   (alu_out),
      .carry (alu_carry)
   );

   // Ready comes only from registered occupancy, so it never sees res_ready.
   assign cmd_ready = (count_q < DEPTH_C);
   assign res_valid = (count_q != '0);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = res_valid && res_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      op_count_d = op_count_q;
      if (push) begin
         wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         op_count_d = op_count_q + 8'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         op_count_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         op_count_q <= op_count_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{out: alu_out, carry: alu_carry};
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign res_out   = res_valid ? head.out : '0;
   assign res_carry = res_valid & head.carry;
   assign res_zero  = (res_out == '0);
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu4_resp.sv
// Self-checking bench for alu4_resp: queue-based reference model with a
// per-cycle compare, directed literal cases and randomized traffic.
module tb_alu4_resp;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       res_ready = 1'b0;
   logic [3:0] cmd_a = '0;
   logic [3:0] cmd_b = '0;
   logic [2:0] cmd_sel = '0;
   logic       cmd_ready;
   logic       res_valid;
   logic [3:0] res_out;
   logic       res_carry;
   logic       res_zero;
   logic [7:0] op_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int out;
      int carry;
   } exp_t;

   exp_t q[$];
   int   cnt_m = 0;

   alu4_resp #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_sel   (cmd_sel),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_out   (res_out),
      .res_carry (res_carry),
      .res_zero  (res_zero),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   function automatic exp_t ref_alu(int a, int b, int sel);
      exp_t r;
      r.out   = 0;
      r.carry = 0;
      case (sel)
         0: begin r.out = (a + b) % 16; r.carry = (a + b > 15) ? 1 : 0; end
         1: begin r.out = (a - b + 16) % 16; r.carry = (a < b) ? 1 : 0; end
         2: r.out = a & b;
         3: r.out = a | b;
         4: r.out = a ^ b;
         5: begin r.out = (a * 2) % 16; r.carry = a / 8; end
         6: begin r.out = a / 2; r.carry = a % 2; end
         default: r.out = (a < b ? 4 : 0) + (a > b ? 2 : 0) + (a == b ? 1 : 0);
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: occupancy, order and counter from the handshake rules.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            q.delete();
            cnt_m = 0;
         end else begin
            bit acc;
            bit pp;
            acc = cmd_valid && (q.size() < DEPTH);
            pp  = res_ready && (q.size() > 0);
            if (pp) void'(q.pop_front());
            if (acc) begin
               q.push_back(ref_alu(int'(cmd_a), int'(cmd_b), int'(cmd_sel)));
               cnt_m = (cnt_m + 1) % 256;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("cmd_ready", cmd_ready, (q.size() < DEPTH));
         chk("res_valid", res_valid, (q.size() != 0));
         chk("op_count", op_count, cnt_m);
         if (q.size() != 0) begin
            chk("res_out", res_out, q[0].out);
            chk("res_carry", res_carry, q[0].carry);
            chk("res_zero", res_zero, (q[0].out == 0));
         end
         if (rst) begin
            chk("rst_out", res_out, 0);
            chk("rst_carry", res_carry, 0);
            chk("rst_zero", res_zero, 1);
         end
      end
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_chk(input string name, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] sel, input int eo, input int ec, input int ez);
      cmd_a = a;
      cmd_b = b;
      cmd_sel = sel;
      cmd_valid = 1'b1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk({name, "_valid"}, res_valid, 1);
      chk({name, "_out"}, res_out, eo);
      chk({name, "_carry"}, res_carry, ec);
      chk({name, "_zero"}, res_zero, ez);
   endtask

   initial begin
      int rdy_cycles;
      logic [3:0] sweep_out [8];
      logic       sweep_c [8];
      sweep_out = '{4'b1000, 4'b0010, 4'b0001, 4'b0111, 4'b0110, 4'b1010, 4'b0010, 4'b0010};
      sweep_c   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_res_valid", res_valid, 0);
      chk("reset_op_count", op_count, 0);

      // Opcode sweep with A=0101, B=0011.
      for (int s = 0; s < 8; s++) begin
         send_chk($sformatf("sweep%0d", s), 4'b0101, 4'b0011, 3'(s),
                  int'(sweep_out[s]), int'(sweep_c[s]), (sweep_out[s] == 4'b0000));
      end
      send_chk("add_wrap", 4'b1111, 4'b0001, 3'b000, 0, 1, 1);
      send_chk("sub_nob", 4'b1111, 4'b0001, 3'b001, 14, 0, 0);
      send_chk("sub_borrow", 4'b0011, 4'b0101, 3'b001, 14, 1, 0);
      @(posedge clk);
      #1 res_ready = 1'b0;

      // Backpressure: fill, pop once, third command goes in next cycle.
      do_reset();
      cmd_a = 4'd1; cmd_b = 4'd2; cmd_sel = 3'b000; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_sel = 3'b001;
      @(posedge clk); #1;
      chk("full_cmd_ready", cmd_ready, 0);
      chk("full_op_count", op_count, 2);
      cmd_sel = 3'b010;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("after_pop_cmd_ready", cmd_ready, 1);
      chk("after_pop_op_count", op_count, 2);
      chk("after_pop_head", res_out, 15);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("third_op_count", op_count, 3);
      chk("third_cmd_ready", cmd_ready, 0);
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 res_ready = 1'b0;

      // Streaming: one accept per cycle.
      do_reset();
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      rdy_cycles = 0;
      repeat (20) begin
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 3'($urandom);
         if (cmd_ready) rdy_cycles++;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      chk("stream_op_count", op_count, 20);
      chk("stream_ready_cycles", rdy_cycles, 20);
      repeat (2) @(posedge clk);
      #1;

      // Asynchronous reset mid-cycle with two results queued.
      do_reset();
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_a = 4'd7; cmd_b = 4'd9; cmd_sel = 3'b000;
      repeat (2) @(posedge clk);
      #1 cmd_valid = 1'b0;
      chk("queued_res_valid", res_valid, 1);
      chk("queued_cmd_ready", cmd_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("async_res_valid", res_valid, 0);
      chk("async_cmd_ready", cmd_ready, 1);
      chk("async_op_count", op_count, 0);
      chk("async_res_out", res_out, 0);
      chk("async_res_zero", res_zero, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      send_chk("post_reset", 4'd2, 4'd3, 3'b000, 5, 0, 0);
      chk("post_reset_op_count", op_count, 1);
      @(posedge clk);
      #1 res_ready = 1'b0;

      // Counter wrap.
      do_reset();
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      repeat (257) begin
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 3'($urandom);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      chk("wrap_op_count", op_count, 1);
      repeat (2) @(posedge clk);
      #1;

      // Randomized traffic, checked by the model every cycle.
      do_reset();
      repeat (400) begin
         cmd_valid = 1'($urandom_range(0, 1));
         res_ready = ($urandom_range(0, 3) != 0);
         cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 3'($urandom);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("drain_res_valid", res_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
